// File: rtl/pft_pkg.sv
// Shared types and helpers for the serial-configured countdown timer.
// Holds the FSM state encoding and counter-width helper.
package pft_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    SHIFT,
    COUNT,
    WAIT
  } state_t;

  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/param_fancy_timer_if.sv
// Serial-config / status bundle for param_fancy_timer.
// slave = timer side, master = driver side.
interface param_fancy_timer_if #(
  parameter int DELAY_W = 4
) ();

  logic               data;
  logic               ack;
  logic               abort;
  logic [DELAY_W-1:0] count;
  logic               counting;
  logic               done;

  modport master (
    output data, ack, abort,
    input  count, counting, done
  );

  modport slave (
    input  data, ack, abort,
    output count, counting, done
  );

endinterface

// File: rtl/pft_pattern_det.sv
// Start-pattern detector: PATTERN_W-1 bit history plus live data bit.
// match is combinational on the current data input.
module pft_pattern_det #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1101
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic data,
  output logic match
);

  logic [PATTERN_W-2:0] r_hist;
  logic [PATTERN_W-1:0] w_win;

  assign w_win = {r_hist, data};
  assign match = (w_win == PATTERN);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_hist <= '0;
    end else begin
      r_hist <= w_win[PATTERN_W-2:0];
    end
  end

endmodule

// File: rtl/param_fancy_timer.sv
// Serial-configured countdown: pattern, DELAY_W-bit delay, count, done.
// Optional abort of SHIFT/COUNT is built with PFT_ABORT_EN defined.
module param_fancy_timer
  import pft_pkg::*;
#(
  parameter int                   PATTERN_W      = 4,
  parameter logic [PATTERN_W-1:0] PATTERN        = 4'b1101,
  parameter int                   DELAY_W        = 4,
  parameter int                   TICKS_PER_UNIT = 1000
) (
  input logic               clk,
  input logic               reset,
  param_fancy_timer_if.slave bus
);

  localparam int TW = clog2_min1(TICKS_PER_UNIT);
  localparam int SW = clog2_min1(DELAY_W);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_UNIT - 1);
  localparam logic [SW-1:0] SH_LAST   = SW'(DELAY_W - 1);

  state_t             r_state;
  state_t             w_next;
  logic [DELAY_W-1:0] r_units;
  logic [DELAY_W-1:0] w_shift_nxt;
  logic [SW-1:0]      r_shcnt;
  logic [TW-1:0]      r_ticks;
  logic               w_match;
  logic               w_det_clr;
  logic               w_wrap;
  logic               w_abort;

  assign w_det_clr = (r_state != SEARCH);
  assign w_wrap    = (r_ticks == TICK_LAST);

  pft_pattern_det #(
    .PATTERN_W (PATTERN_W),
    .PATTERN   (PATTERN)
  ) u_det (
    .clk   (clk),
    .reset (reset),
    .clear (w_det_clr),
    .data  (bus.data),
    .match (w_match)
  );

  // r_units doubles as the delay shift register while in SHIFT
  if (DELAY_W > 1) begin : g_shw
    assign w_shift_nxt = {r_units[DELAY_W-2:0], bus.data};
  end else begin : g_sh1
    assign w_shift_nxt = bus.data;
  end

`ifdef PFT_ABORT_EN
  assign w_abort = bus.abort &&
                   (r_state == SHIFT || r_state == COUNT);
`else
  assign w_abort = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      SEARCH: if (w_match) w_next = SHIFT;
      SHIFT:  if (r_shcnt == SH_LAST) w_next = COUNT;
      COUNT:  if (r_units == '0 && w_wrap) w_next = WAIT;
      WAIT:   if (bus.ack) w_next = SEARCH;
      default: w_next = SEARCH;
    endcase
    if (w_abort) w_next = SEARCH;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SEARCH;
      r_units <= '0;
      r_shcnt <= '0;
      r_ticks <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        SEARCH: begin
          r_shcnt <= '0;
          r_ticks <= '0;
        end
        SHIFT: begin
          r_units <= w_shift_nxt;
          r_shcnt <= r_shcnt + SW'(1);
          r_ticks <= '0;
        end
        COUNT: begin
          if (w_wrap) begin
            r_ticks <= '0;
            if (r_units != '0) r_units <= r_units - DELAY_W'(1);
          end else begin
            r_ticks <= r_ticks + TW'(1);
          end
        end
        default: ;
      endcase
      if (w_abort) begin
        r_units <= '0;
        r_shcnt <= '0;
        r_ticks <= '0;
      end
    end
  end

  assign bus.counting = (r_state == COUNT);
  assign bus.done     = (r_state == WAIT);
  assign bus.count    = (r_state == COUNT) ? r_units : '0;

endmodule
